// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmit-side blocks.
//
//   BYTE_W         width of one UART data byte
//   drain_state_t  state encoding of the FIFO drain FSM in uart_tx_fifo
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    DRAIN_IDLE      = 2'd0,
    DRAIN_ISSUE     = 2'd1,
    DRAIN_WAIT_BUSY = 2'd2,
    DRAIN_WAIT_IDLE = 2'd3
  } drain_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
//   DEPTH x BYTE_W storage array for the transmit FIFO. One synchronous write
//   port and one combinational read port. The contents are not reset.
//
//   clk    system clock
//   we     write enable, stores wdata at waddr on the rising edge
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  data at raddr, combinational
// -----------------------------------------------------------------------------
module sync_fifo_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO in front of uart_tx. Producers push bytes with a single-cycle
//   strobe; the drain FSM hands them to the serializer one at a time, each
//   with a one-cycle load pulse, whenever the transmitter reports idle.
//
//   clk         system clock
//   rst         asynchronous active-low reset
//   wr_en       producer write strobe, one byte per high cycle
//   din         byte to enqueue, sampled when wr_en=1
//   full        FIFO holds DEPTH entries
//   fifo_empty  FIFO holds no entries
//   count       occupancy, 0..DEPTH
//   overflow    sticky, a write was attempted while full (cleared by reset)
//   tx_empty    from uart_tx, transmitter idle and able to take a byte
//   tx_wr_en    to uart_tx, one-cycle load pulse
//   tx_byte     to uart_tx, valid with tx_wr_en and held afterwards
//
//   DEPTH must be a power of two in 2..256 so the pointers wrap naturally.
//
//   Drain FSM
//   state            | meaning
//   -----------------+----------------------------------------------------
//   DRAIN_IDLE       | waiting for data and an idle transmitter; pops here
//   DRAIN_ISSUE      | tx_wr_en high for exactly this one cycle
//   DRAIN_WAIT_BUSY  | waiting for uart_tx to drop tx_empty (byte taken)
//   DRAIN_WAIT_IDLE  | waiting for uart_tx to finish the frame
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] din,
  output logic              full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              tx_empty,
  output logic              tx_wr_en,
  output logic [BYTE_W-1:0] tx_byte
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [BYTE_W-1:0] rd_data;
  drain_state_t      state;

  logic              wr_accept;
  logic              pop;
  logic [ADDR_W:0]   count_nxt;

  // Acceptance is judged on the registered (pre-edge) full flag, so a write
  // that coincides with a pop from a full FIFO is still rejected.
  assign wr_accept = wr_en & ~full;
  assign pop       = (state == DRAIN_IDLE) & ~fifo_empty & tx_empty;
  assign count_nxt = count + (ADDR_W + 1)'(wr_accept) - (ADDR_W + 1)'(pop);

  sync_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Write side and occupancy. count is the single source of truth for the
  // full/empty flags, so equal pointers never need disambiguating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      fifo_empty <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      count      <= count_nxt;
      full       <= (count_nxt == DEPTH_CNT);
      fifo_empty <= (count_nxt == '0);
    end
  end

  // Drain FSM. Waiting for tx_empty to fall and then rise again keeps a
  // second load pulse away until uart_tx has registered the first byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DRAIN_IDLE;
      rd_ptr   <= '0;
      tx_wr_en <= 1'b0;
      tx_byte  <= '0;
    end else begin
      case (state)
        DRAIN_IDLE: begin
          tx_wr_en <= 1'b0;
          if (pop) begin
            tx_byte  <= rd_data;
            tx_wr_en <= 1'b1;
            rd_ptr   <= rd_ptr + 1'b1;
            state    <= DRAIN_ISSUE;
          end
        end
        DRAIN_ISSUE: begin
          tx_wr_en <= 1'b0;
          state    <= DRAIN_WAIT_BUSY;
        end
        DRAIN_WAIT_BUSY: begin
          if (!tx_empty) begin
            state <= DRAIN_WAIT_IDLE;
          end
        end
        DRAIN_WAIT_IDLE: begin
          if (tx_empty) begin
            state <= DRAIN_IDLE;
          end
        end
        default: begin
          tx_wr_en <= 1'b0;
          state    <= DRAIN_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int FRAME = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       full;
  logic       fifo_empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_empty;
  logic       tx_wr_en;
  logic [7:0] tx_byte;

  // transmitter stand-in: busy for FRAME cycles after each load pulse,
  // or forced busy by the stimulus through hold_busy
  int   busy_cnt = 0;
  logic hold_busy = 1'b0;
  assign tx_empty = (busy_cnt == 0) && !hold_busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] out_log[$];

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .din        (din),
    .full       (full),
    .fifo_empty (fifo_empty),
    .count      (count),
    .overflow   (overflow),
    .tx_empty   (tx_empty),
    .tx_wr_en   (tx_wr_en),
    .tx_byte    (tx_byte)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst) busy_cnt = 0;
    else if (tx_wr_en) busy_cnt = FRAME;
    else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
  end

  // Reference model: a byte queue plus the load handshake (one-cycle pulse,
  // then the transmitter must be seen busy and then idle before the next pop).
  logic [7:0] m_q[$];
  logic       m_ovf = 1'b0;
  logic       m_pulse = 1'b0;
  logic       m_need_busy = 1'b0;
  logic       m_need_idle = 1'b0;
  logic [7:0] m_byte = 8'h00;

  always @(posedge clk) begin
    logic can_pop;
    logic wr_ok;
    if (!rst) begin
      m_q.delete();
      m_ovf = 1'b0; m_pulse = 1'b0; m_need_busy = 1'b0; m_need_idle = 1'b0;
      m_byte = 8'h00;
    end else begin
      can_pop = !m_pulse && !m_need_busy && !m_need_idle && (m_q.size() > 0) && tx_empty;
      wr_ok   = wr_en && (m_q.size() < DEPTH);
      if (wr_en && !wr_ok) m_ovf = 1'b1;
      if (m_pulse) begin
        m_pulse = 1'b0; m_need_busy = 1'b1;
      end else if (m_need_busy && !tx_empty) begin
        m_need_busy = 1'b0; m_need_idle = 1'b1;
      end else if (m_need_idle && tx_empty) begin
        m_need_idle = 1'b0;
      end
      if (can_pop) begin
        m_byte  = m_q.pop_front();
        m_pulse = 1'b1;
      end
      if (wr_ok) m_q.push_back(din);
    end
    #1;
    chk("count", count, m_q.size());
    chk("full", full, (m_q.size() == DEPTH));
    chk("fifo_empty", fifo_empty, (m_q.size() == 0));
    chk("overflow", overflow, m_ovf);
    chk("tx_wr_en", tx_wr_en, m_pulse);
    chk("tx_byte", tx_byte, m_byte);
    if (tx_wr_en) out_log.push_back(tx_byte);
  end

  task automatic wr_byte(input logic [7:0] b);
    wr_en = 1'b1;
    din   = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (!(fifo_empty && tx_empty && !tx_wr_en) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", (n < max_cyc), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_fifo_empty", fifo_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_wr_en", tx_wr_en, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    rst = 1'b1;
    @(negedge clk);

    // single byte: pulse appears two edges after the write
    wr_byte(8'hF0);
    chk("single_count1", count, 1);
    chk("single_no_pulse_yet", tx_wr_en, 0);
    @(negedge clk);
    chk("single_pulse", tx_wr_en, 1);
    chk("single_byte", tx_byte, 8'hF0);
    chk("single_count0", count, 0);
    @(negedge clk);
    chk("single_pulse_end", tx_wr_en, 0);
    chk("single_byte_held", tx_byte, 8'hF0);
    drain(100);

    // burst order
    out_log.delete();
    wr_byte(8'h01);
    wr_byte(8'h02);
    wr_byte(8'h03);
    drain(300);
    chk("burst_len", out_log.size(), 3);
    chk("burst_0", out_log[0], 8'h01);
    chk("burst_1", out_log[1], 8'h02);
    chk("burst_2", out_log[2], 8'h03);

    // fill and overflow with the transmitter held busy
    out_log.delete();
    hold_busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) wr_byte(8'(8'h10 + i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_no_ovf", overflow, 0);
    wr_byte(8'h20);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    chk("ovf_no_pulse", out_log.size(), 0);
    hold_busy = 1'b0;
    drain(600);
    chk("ovf_drain_len", out_log.size(), 16);
    for (int i = 0; i < 16; i++) chk("ovf_drain_order", out_log[i], 8'(8'h10 + i));
    chk("ovf_sticky", overflow, 1);

    // mid-run reset with five bytes queued
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) wr_byte(8'(8'h50 + i));
    chk("prerst_count", count, 5);
    rst = 1'b0;
    hold_busy = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_fifo_empty", fifo_empty, 1);
    chk("midrst_full", full, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_tx_wr_en", tx_wr_en, 0);
    @(negedge clk);
    rst = 1'b1;
    out_log.delete();
    repeat (10) @(negedge clk);
    chk("postrst_no_pulse", out_log.size(), 0);
    chk("postrst_empty", fifo_empty, 1);

    // write coinciding with a pop at count=4
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) wr_byte(8'(8'hA0 + i));
    chk("simul_pre_count", count, 4);
    hold_busy = 1'b0;
    wr_byte(8'hA4);
    chk("simul_count", count, 4);
    chk("simul_pulse", tx_wr_en, 1);
    chk("simul_byte", tx_byte, 8'hA0);
    drain(400);
    chk("simul_len", out_log.size(), 5);
    for (int i = 0; i < 5; i++) chk("simul_order", out_log[i], 8'(8'hA0 + i));

    // write while full coinciding with a pop: write rejected
    out_log.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) wr_byte(8'(8'hB0 + i));
    chk("fullpop_pre_full", full, 1);
    chk("fullpop_pre_ovf", overflow, 0);
    hold_busy = 1'b0;
    wr_byte(8'hCC);
    chk("fullpop_count", count, 15);
    chk("fullpop_ovf", overflow, 1);
    chk("fullpop_full", full, 0);
    chk("fullpop_pulse", tx_wr_en, 1);
    chk("fullpop_byte", tx_byte, 8'hB0);
    drain(600);
    chk("fullpop_len", out_log.size(), 16);
    for (int i = 0; i < 16; i++) chk("fullpop_order", out_log[i], 8'(8'hB0 + i));

    // wrap-around: 40 bytes in groups of ten
    out_log.delete();
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 10; i++) wr_byte(8'(g * 10 + i));
      drain(400);
    end
    chk("wrap_len", out_log.size(), 40);
    for (int i = 0; i < 40; i++) chk("wrap_order", out_log[i], 8'(i));
    chk("wrap_empty", fifo_empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO placed directly upstream of uart_tx. It decouples bursty producers (command logic, a debug dumper) from the 9600-baud serializer.
- Accepts bytes on a single-cycle write strobe, buffers up to DEPTH entries, and drains them one at a time.
- Drains by pulsing uart_tx's wr_en/byte inputs whenever the transmitter reports tx_empty.
- Also provides occupancy, full/empty and sticky overflow status.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, 2..256.
- ADDR_W, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
- clk  input  1  system clock (100 MHz nominal)
- rst  input  1  asynchronous, active-low reset
- wr_en  input  1  producer write strobe; one byte per high cycle
- din  input  8  byte to enqueue, sampled when wr_en=1
- full  output  1  FIFO holds DEPTH entries
- fifo_empty  output  1  FIFO holds 0 entries
- count  output  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky; a write was attempted while full
- tx_empty  input  1  from uart_tx: transmitter idle, can accept a byte
- tx_wr_en  output  1  to uart_tx wr_en: one-cycle load pulse
- tx_byte  output  8  to uart_tx byte: valid while tx_wr_en=1, held afterwards

Behaviour:
- Reset (rst=0, async): wr_ptr=0, rd_ptr=0, count=0, full=0, fifo_empty=1, overflow=0, tx_wr_en=0, tx_byte=8'h00, state=IDLE. Memory contents are not reset.
- All logic is on the posedge of clk. full, fifo_empty and count are registered and update on the same edge as the write or pop.
- Write: when wr_en=1 and full=0 at the edge, mem[wr_ptr]<=din, wr_ptr increments modulo DEPTH, count increments.
- Write while full (full=1 at the edge) is dropped: no pointer or count change, overflow<=1. overflow clears only on reset.
- The pop is defined as the ISSUE transition below.
- Simultaneous write and pop:
  - Both take effect; count is unchanged.
  - If full=1 at that edge, the write is still rejected, because acceptance is judged on pre-edge full. overflow sets and count drops by 1.
- Pointers wrap from DEPTH-1 to 0. count is the authority for full/empty; no pointer-compare ambiguity.
- Drain FSM states:
  - IDLE: tx_wr_en=0. If fifo_empty=0 and tx_empty=1, then tx_byte<=mem[rd_ptr], tx_wr_en<=1, rd_ptr++, count--, go to ISSUE.
  - ISSUE: lasts one cycle with tx_wr_en=1. Next edge: tx_wr_en<=0, go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_empty=0 (the transmitter accepted the byte), then go to WAIT_IDLE. Prevents a second pulse before uart_tx has registered the first.
  - WAIT_IDLE: wait for tx_empty=1, then go to IDLE.
- Latency: a byte written at edge N into an empty FIFO, with tx_empty=1, produces tx_wr_en=1 for the cycle after edge N+1.
- Back-to-back bytes have a minimum 3-cycle gap plus the full serial frame time.
- tx_byte holds its last value outside ISSUE.
- No reordering; bytes leave in write order.
- Reset mid-operation: everything returns to reset values immediately. A frame already loaded into uart_tx is that module's concern; queued bytes are discarded.
- tx_empty=0 at reset release: the FSM stays in IDLE until tx_empty=1.

Decomposition:
- Shared package uart_pkg holds:
  - BYTE_W=8;
  - the drain state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT_BUSY=2'd2, WAIT_IDLE=2'd3).
- One sub-module, sync_fifo_mem: DEPTH x 8 register array with write port and combinational read at rd_ptr.
- Pointer, count and FSM logic stay in uart_tx_fifo.

Test Plan:
- Reset: assert rst=0 mid-run with count=5 -> immediately count=0, fifo_empty=1, full=0, overflow=0, tx_wr_en=0. After release the FSM is idle and no pulse occurs.
- Single byte:
  - Stimulus: tx_empty=1, write 8'hF0.
  - Response: tx_wr_en high for exactly one cycle, two edges after the write, with tx_byte=8'hF0. count goes 1 then 0.
  - With real uart_tx attached, uart_rx byte=8'hF0 after about 1.05 ms.
- Burst order:
  - Stimulus: write 8'h01, 8'h02, 8'h03 on consecutive cycles with uart_tx attached at BAUD=9600.
  - Response: uart_rx receives 01, 02, 03 in order; exactly 3 tx_wr_en pulses. No pulse while tx_empty=0.
- Fill/overflow:
  - Stimulus: hold tx_empty=0 and write 17 bytes 8'h10..8'h20 with DEPTH=16.
  - Response: full=1 after the 16th byte, count=16, 17th dropped, overflow=1.
  - Then release tx_empty: drained bytes are 8'h10..8'h1F only.
- Simultaneous write and pop:
  - Stimulus: count=4, write in the same cycle as ISSUE -> count stays 4.
  - Stimulus: at full=1, write during ISSUE -> count=15, overflow=1.
- Wrap-around: write and drain 40 bytes 0..39 through DEPTH=16 -> output sequence 0..39 intact; fifo_empty=1 at the end.
